// File: rtl/fetch_decode.sv
// Front end of the 9-bit-instruction core: PC, one-deep decode register,
// field split, branch/halt resolution with a one-bubble flush on taken BNZ.
module fetch_decode #(
  parameter int PW = 10,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  output logic [PW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          zero_flag,
  input  logic [PW-1:0] br_target,
  output logic [2:0]    opcode,
  output logic [2:0]    rd,
  output logic [2:0]    rs,
  output logic [2:0]    imm_code,
  output logic          imm_en,
  output logic [2:0]    lut_idx,
  output logic          instr_valid,
  output logic          running,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_BNZ = 3'b110;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          is_halt, is_taken;

  // A flushed (invalid) halt or branch must never act, so both qualify on valid_q.
  assign is_halt  = valid_q && (ir_q == {IW{1'b1}});
  assign is_taken = valid_q && !stall && (ir_q[8:6] == OP_BNZ) && !zero_flag;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (is_halt) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (is_taken) begin
          pc_d    = br_target;
          valid_d = 1'b0;
        end else if (!stall) begin
          ir_d    = imem_data;
          valid_d = 1'b1;
          pc_d    = pc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr   = pc_q;
  assign opcode      = ir_q[8:6];
  assign rd          = ir_q[5:3];
  assign rs          = ir_q[2:0];
  assign imm_code    = ir_q[2:0];
  assign lut_idx     = ir_q[2:0];
  assign imm_en      = valid_q && (ir_q[8:6] == OP_LDI);
  assign instr_valid = valid_q;
  assign running     = (state_q == S_RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: reset, fetch/LDI decode, branch, stall,
// halt/restart on a PW=10 instance and PC wrap on a PW=4 instance.
module tb_fetch_decode;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       zero_flag;
  logic [9:0] br_target;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [2:0] opcode, rd, rs, imm_code, lut_idx;
  logic       imm_en, instr_valid, running, done;

  logic       w_start;
  logic [3:0] w_addr;
  logic [8:0] w_data;
  logic [2:0] w_opcode, w_rd, w_rs, w_imm_code, w_lut_idx;
  logic       w_imm_en, w_valid, w_running, w_done;

  logic [8:0] rom [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  assign imem_data = rom[imem_addr];
  assign w_data    = 9'h000;

  fetch_decode #(.PW(10), .IW(9)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .zero_flag(zero_flag), .br_target(br_target),
    .opcode(opcode), .rd(rd), .rs(rs), .imm_code(imm_code),
    .imm_en(imm_en), .lut_idx(lut_idx), .instr_valid(instr_valid),
    .running(running), .done(done)
  );

  fetch_decode #(.PW(4), .IW(9)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .stall(1'b0),
    .imem_addr(w_addr), .imem_data(w_data),
    .zero_flag(1'b1), .br_target(4'd0),
    .opcode(w_opcode), .rd(w_rd), .rs(w_rs), .imm_code(w_imm_code),
    .imm_en(w_imm_en), .lut_idx(w_lut_idx), .instr_valid(w_valid),
    .running(w_running), .done(w_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[0]  = 9'b101_010_011;
    rom[1]  = 9'b000_001_010;
    rom[4]  = 9'b110_000_010;
    rom[5]  = 9'b011_111_101;
    rom[20] = 9'b010_100_001;

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; zero_flag = 1'b1;
    br_target = 10'd20; w_start = 1'b0;
    steps(2);
    check("rst_addr", imem_addr, 0);
    check("rst_run", running, 0);
    check("rst_done", done, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_imm_en", imm_en, 0);
    rst_n = 1'b1;
    step();
    check("idle_hold", running, 0);

    // Start and sequential fetch with LDI decode
    pulse_start();
    check("start_addr", imem_addr, 0);
    check("start_run", running, 1);
    check("start_valid", instr_valid, 0);
    step();
    check("c2_valid", instr_valid, 1);
    check("c2_opcode", opcode, 5);
    check("c2_rd", rd, 2);
    check("c2_imm_code", imm_code, 3);
    check("c2_imm_en", imm_en, 1);
    check("c2_addr", imem_addr, 1);
    step();
    check("c3_opcode", opcode, 0);
    check("c3_rs", rs, 2);
    check("c3_rd", rd, 1);
    check("c3_imm_en", imm_en, 0);
    steps(3);
    check("bnz_in_dec", opcode, 6);
    check("bnz_lut_idx", lut_idx, 2);
    check("bnz_addr", imem_addr, 5);
    // zero_flag=1: not taken, ROM[5] decodes
    step();
    check("nt_addr", imem_addr, 6);
    check("nt_valid", instr_valid, 1);
    check("nt_opcode", opcode, 3);
    check("nt_rd", rd, 7);
    step();
    check("pc7", imem_addr, 7);

    // Asynchronous reset mid-run, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", imem_addr, 0);
    check("arst_run", running, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_opcode", opcode, 0);
    step();
    rst_n = 1'b1;

    // Stall on a BNZ with zero_flag=0, then taken branch
    pulse_start();
    steps(5);
    check("br_dec", opcode, 6);
    zero_flag = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr, 5);
      check("stall_valid", instr_valid, 1);
      check("stall_opcode", opcode, 6);
    end
    stall = 1'b0;
    step();
    check("tk_addr", imem_addr, 20);
    check("tk_valid", instr_valid, 0);
    zero_flag = 1'b1;
    step();
    check("tgt_valid", instr_valid, 1);
    check("tgt_opcode", opcode, 2);
    check("tgt_rd", rd, 4);
    check("tgt_addr", imem_addr, 21);
    // start while running is ignored
    pulse_start();
    check("run_start_ign", imem_addr, 22);
    check("run_start_run", running, 1);

    // Halt at ROM[3], retiring under stall
    rom[3] = 9'h1FF;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pulse_start();
    steps(4);
    check("halt_dec_valid", instr_valid, 1);
    check("halt_dec_addr", imem_addr, 4);
    stall = 1'b1;
    step();
    check("halt_done", done, 1);
    check("halt_run", running, 0);
    check("halt_addr", imem_addr, 4);
    check("halt_valid", instr_valid, 0);
    stall = 1'b0;
    steps(2);
    check("done_hold", done, 1);
    check("done_addr", imem_addr, 4);
    pulse_start();
    check("restart_addr", imem_addr, 0);
    check("restart_done", done, 0);
    check("restart_run", running, 1);
    step();
    check("restart_opcode", opcode, 5);

    // PC wrap on the PW=4 instance
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    check("w_start_addr", w_addr, 0);
    steps(14);
    check("w_pc14", w_addr, 14);
    step();
    check("w_pc15", w_addr, 15);
    step();
    check("w_pc0", w_addr, 0);
    check("w_run0", w_running, 1);
    step();
    check("w_pc1", w_addr, 1);
    check("w_run1", w_running, 1);
    check("w_done", w_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Front-end stage of the 9-bit-instruction core.
- Owns the program counter, fetches from the combinational instruction ROM, and registers the instruction in a one-deep decode register.
- Splits the registered instruction into opcode, register and immediate-code fields. The 3-bit immediate code feeds the immediate-expansion LUT directly downstream.
- Resolves branches and halt, and flushes the wrong-path fetch on a taken branch.

Parameters:
- PW, 10, program counter / instruction address width.
- IW, 9, instruction width; field positions below assume 9.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin execution at PC 0; sampled only in IDLE or DONE.
- stall  input  1  freeze PC and decode register for this cycle.
- imem_addr  output  PW  instruction ROM address; equals pc.
- imem_data  input  IW  ROM read data, combinational from imem_addr.
- zero_flag  input  1  ALU zero flag, valid in the cycle the branch sits in decode.
- br_target  input  PW  target from the branch LUT, indexed by lut_idx.
- opcode  output  3  ir[8:6].
- rd  output  3  ir[5:3].
- rs  output  3  ir[2:0].
- imm_code  output  3  ir[2:0]; drives the immediate-expansion LUT select.
- imm_en  output  1  instr_valid and opcode==3'b101 (LDI).
- lut_idx  output  3  ir[2:0]; branch LUT index.
- instr_valid  output  1  decode register holds a live instruction.
- running  output  1  state==RUN.
- done  output  1  state==DONE.

Behaviour:
- Reset (rst_n low, asynchronous, any state, mid-run included):
  - state=IDLE, pc=0, ir=0, instr_valid=0, done=0.
  - Therefore running=0, imm_en=0, imem_addr=0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 → pc<=0, instr_valid<=0, go RUN.
  - start=0 → hold.
- RUN, evaluated each rising edge with priority halt > taken branch > stall > advance:
  - Halt: instr_valid=1 and ir==9'b111_111111 → go DONE, instr_valid<=0, pc holds. The halt retires even if stall=1.
  - Taken branch: stall=0, instr_valid=1, opcode==3'b110 (BNZ), zero_flag==0 → pc<=br_target, instr_valid<=0. The instruction fetched this cycle is discarded. Penalty is 1 bubble.
  - Not-taken BNZ: behaves as advance.
  - Stall: stall=1 and no halt → pc, ir and instr_valid all hold; no branch is evaluated.
  - Advance: ir<=imem_data, instr_valid<=1, pc<=pc+1.
- Latency: an instruction at address A appears in decode one cycle after pc==A.
- Decode outputs are pure functions of ir and instr_valid; there is no extra register. imm_code reaches the immediate LUT in the same cycle.
- PC arithmetic is modulo 2^PW: pc=2^PW-1 advances to 0 with no flag.
- DONE:
  - done=1 and pc is frozen.
  - start=1 → pc<=0, instr_valid<=0, done<=0, go RUN.
  - start is ignored while in RUN.
- Field outputs (opcode/rd/rs/imm_code/lut_idx) reflect ir even when instr_valid=0. Consumers must qualify with instr_valid; imm_en is already qualified.
- The halt pattern is tested only when instr_valid=1, so a flushed halt never stops the core.
- Deassertion of rst_n needs no synchronizer inside this block; it is supplied at top level.

Test Plan:
- Reset/start:
  - Stimulus: assert rst_n=0 mid-RUN with pc=7, release, then pulse start.
  - Required: outputs return to reset values immediately. The cycle after start: imem_addr=0, running=1. The next cycle: instr_valid=1 with ir=ROM[0].
- Sequential fetch + LDI:
  - Stimulus: ROM[0]=9'b101_010_011, ROM[1]=9'b000_001_010.
  - Required: cycle 2 gives opcode=5, rd=2, imm_code=3, imm_en=1. Cycle 3 gives opcode=0, rs=2, imm_en=0.
- Branch taken vs not:
  - Stimulus: ROM[4]=BNZ lut_idx=2 and br_target=20.
  - With zero_flag=0: next imem_addr=20, instr_valid drops for one cycle, ROM[5] never decodes.
  - With zero_flag=1: next imem_addr=6 and ROM[5] decodes normally.
- Stall:
  - Stimulus: hold stall=1 for 3 cycles with BNZ in decode and zero_flag=0.
  - Required: pc and ir unchanged for all 3 cycles; the branch is taken only on the first unstalled cycle.
- Halt/restart:
  - Stimulus: ROM[3]=9'h1FF, with stall=1 in the halt's decode cycle.
  - Required: done=1 next cycle and pc frozen at 4. Start then gives imem_addr=0 and done=0.
- Wrap:
  - Stimulus: PW=4, ROM full of NOP opcodes (0).
  - Required: pc sequence 14, 15, 0, 1 with no state change.
